// File: rtl/shift_ram_mt_if.sv
// Sample/strobe inputs and scan outputs of one shift_ram_mt correlator stage.
// The master drives samples. The slave is the delay line itself.
interface shift_ram_mt_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  logic             clr;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dshift;
  logic             dshift_vld;
  logic [AW-1:0]    dshift_lag;
  logic             sout;
  logic             busy;
  logic             ovf;

  modport master (
    output clr, din, sin,
    input  dout, dshift, dshift_vld, dshift_lag, sout, busy, ovf
  );

  modport slave (
    input  clr, din, sin,
    output dout, dshift, dshift_vld, dshift_lag, sout, busy, ovf
  );
endinterface

// File: rtl/shift_ram_mt.sv
// RAM delay line for one multi-tau stage: stores each sin sample, streams all lags newest-first (SHIFTRAM_CLR_EN adds RAM clear).
// Latency: lag 0 valid one cycle after the accepted sin, then DEPTH back-to-back beats.
// No backpressure: a sin while busy is dropped and recorded in the sticky ovf flag.
module shift_ram_mt #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input logic           clk,
  input logic           rst_n,
  shift_ram_mt_if.slave bus
);
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN
`ifdef SHIFTRAM_CLR_EN
    , CLEAR
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ram [DEPTH];

  logic [AW-1:0]    base, base_nxt;
  logic [AW-1:0]    rd, rd_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] dout, dout_nxt;
  logic [WIDTH-1:0] dshift;
  logic [AW-1:0]    dshift_lag, lag_nxt;
  logic             dshift_vld, vld_nxt;
  logic             sout, sout_nxt;
  logic             busy;
  logic             ovf, ovf_nxt;
  logic             scan_beat;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    rd_nxt    = rd;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    lag_nxt   = dshift_lag;
    vld_nxt   = 1'b0;
    sout_nxt  = 1'b0;
    ovf_nxt   = ovf;
    scan_beat = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = base;
    ram_wdata = bus.din;

    case (state)
      IDLE: begin
        if (bus.sin) begin
          ram_we    = 1'b1;
          dout_nxt  = bus.din;
          rd_nxt    = base;
          cnt_nxt   = '0;
          base_nxt  = base + 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // The word at rd was written on an earlier edge, so no write-read bypass is needed.
        scan_beat = 1'b1;
        vld_nxt   = 1'b1;
        lag_nxt   = cnt;
        sout_nxt  = (cnt == '0);
        rd_nxt    = rd - 1'b1;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
        if (bus.sin)     ovf_nxt   = 1'b1;
      end
`ifdef SHIFTRAM_CLR_EN
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = '0;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

`ifdef SHIFTRAM_CLR_EN
    // clr takes priority over an incoming sample and aborts any scan in progress.
    if (bus.clr && state != CLEAR) begin
      state_nxt = CLEAR;
      base_nxt  = '0;
      cnt_nxt   = '0;
      rd_nxt    = rd;
      dout_nxt  = '0;
      ovf_nxt   = 1'b0;
      lag_nxt   = dshift_lag;
      vld_nxt   = 1'b0;
      sout_nxt  = 1'b0;
      scan_beat = 1'b0;
      ram_we    = 1'b0;
    end
`else
    if (bus.clr) ovf_nxt = 1'b0;
`endif
  end

  // RAM has no reset, so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      rd         <= '0;
      cnt        <= '0;
      dout       <= '0;
      dshift     <= '0;
      dshift_lag <= '0;
      dshift_vld <= 1'b0;
      sout       <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      base       <= base_nxt;
      rd         <= rd_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      dshift_lag <= lag_nxt;
      dshift_vld <= vld_nxt;
      sout       <= sout_nxt;
      busy       <= (state_nxt != IDLE);
      ovf        <= ovf_nxt;
      if (scan_beat) dshift <= ram[rd];
    end
  end

  assign bus.dout       = dout;
  assign bus.dshift     = dshift;
  assign bus.dshift_vld = dshift_vld;
  assign bus.dshift_lag = dshift_lag;
  assign bus.sout       = sout;
  assign bus.busy       = busy;
  assign bus.ovf        = ovf;
endmodule

// File: tb/tb_shift_ram_mt.sv
// Bench for shift_ram_mt: an 8-bit/32-word stage and a 16-bit/8-word stage, checked against a lag model.
module tb_shift_ram_mt;
  localparam int DA = 32;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_ram_mt_if #(.WIDTH(8),  .AW(5)) a ();
  shift_ram_mt_if #(.WIDTH(16), .AW(3)) b ();

  shift_ram_mt #(.WIDTH(8),  .AW(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  shift_ram_mt #(.WIDTH(16), .AW(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  // Model: memory image indexed by write address plus the next write address.
  logic [7:0]  mem_m  [DA];
  int          base_m;
  logic [7:0]  dout_m;
  logic [15:0] memb_m [DB];
  int          baseb_m;

  logic [7:0] cap_dat [DA];
  int cap_beats, cap_order_bad, cap_sout_bad;
  logic cap_busy_prev, cap_busy_last;

  function automatic logic [7:0] exp_lag(input int k);
    return mem_m[(base_m + 2 * DA - 1 - k) % DA];
  endfunction

  function automatic logic [15:0] expb_lag(input int k);
    return memb_m[(baseb_m + 2 * DB - 1 - k) % DB];
  endfunction

  task automatic model_wr(input logic [7:0] d);
    mem_m[base_m] = d;
    base_m        = (base_m + 1) % DA;
    dout_m        = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DA; i++) mem_m[i] = 8'h00;
    base_m = 0;
    dout_m = 8'h00;
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic send_a(input logic [7:0] d);
    a.din = d;
    a.sin = 1'b1;
    @(negedge clk);
    a.sin = 1'b0;
  endtask

  task automatic pulse_clr();
    a.clr = 1'b1;
    @(negedge clk);
    a.clr = 1'b0;
`ifdef SHIFTRAM_CLR_EN
    model_clear();
    repeat (DA + 1) @(negedge clk);
`endif
  endtask

  // Records one scan starting at the negedge just after the accepting edge.
  task automatic capture_a(input int inject_at, input logic [7:0] inj_d);
    cap_beats = 0; cap_order_bad = 0; cap_sout_bad = 0;
    for (int k = 0; k < DA; k++) cap_dat[k] = 8'hxx;
    for (int i = 1; i <= DA + 2; i++) begin
      @(negedge clk);
      a.sin = 1'b0;
      if (a.dshift_vld === 1'b1) begin
        cap_beats++;
        if (i > DA || a.dshift_lag !== 5'(i - 1)) cap_order_bad++;
        else cap_dat[i - 1] = a.dshift;
        if (a.sout !== (i == 1)) cap_sout_bad++;
      end else begin
        if (i <= DA) cap_order_bad++;
        if (a.sout !== 1'b0) cap_sout_bad++;
      end
      if (i == DA - 1) cap_busy_prev = a.busy;
      if (i == DA)     cap_busy_last = a.busy;
      if (i == inject_at) begin
        a.din = inj_d;
        a.sin = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a.clr = 1'b0; a.sin = 1'b0; a.din = 8'h00;
    b.clr = 1'b0; b.sin = 1'b0; b.din = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a.dout, a.dshift, a.dshift_vld, a.dshift_lag, a.sout, a.busy, a.ovf} !== '0) begin
      failures++;
      $display("FAIL reset_a: got dout=%h dshift=%h vld=%b lag=%0d sout=%b busy=%b ovf=%b, want all 0",
               a.dout, a.dshift, a.dshift_vld, a.dshift_lag, a.sout, a.busy, a.ovf);
    end
    checks++;
    if ({b.dout, b.dshift, b.dshift_vld, b.dshift_lag, b.sout, b.busy, b.ovf} !== '0) begin
      failures++;
      $display("FAIL reset_b: outputs not all 0 (dout=%h vld=%b busy=%b)", b.dout, b.dshift_vld, b.busy);
    end
  endtask

  task automatic test_basic();
    send_a(8'h11); model_wr(8'h11); repeat (DA + 2) @(negedge clk);
    send_a(8'h22); model_wr(8'h22); repeat (DA + 2) @(negedge clk);
    send_a(8'h33); model_wr(8'h33);
    checks++;
    if (a.dout !== 8'h33 || a.busy !== 1'b1) begin
      failures++; $display("FAIL basic_dout_busy: got dout=%h busy=%b want 33/1", a.dout, a.busy);
    end
    capture_a(0, 8'h00);
    for (int k = 0; k < DA; k++) begin
      checks++;
      if (cap_dat[k] !== exp_lag(k)) begin
        failures++; $display("FAIL basic_lag%0d: got %h want %h", k, cap_dat[k], exp_lag(k));
      end
    end
    checks++;
    if (cap_beats != DA || cap_order_bad != 0) begin
      failures++; $display("FAIL basic_beats: got %0d beats, %0d misplaced, want %0d/0", cap_beats, cap_order_bad, DA);
    end
    checks++;
    if (cap_sout_bad != 0) begin
      failures++; $display("FAIL basic_sout: got %0d bad sout cycles want 0", cap_sout_bad);
    end
    checks++;
    if (cap_busy_prev !== 1'b1 || cap_busy_last !== 1'b0) begin
      failures++; $display("FAIL basic_busy_fall: got %b%b want 10", cap_busy_prev, cap_busy_last);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 40; i++) begin
      send_a(8'(i)); model_wr(8'(i));
      if (i < 40) repeat (DA) @(negedge clk);
    end
    capture_a(0, 8'h00);
    for (int k = 0; k < DA; k++) begin
      checks++;
      if (cap_dat[k] !== exp_lag(k)) begin
        failures++; $display("FAIL b2b_lag%0d: got %h want %h", k, cap_dat[k], exp_lag(k));
      end
    end
    checks++;
    if (a.ovf !== 1'b0 || cap_beats != DA) begin
      failures++; $display("FAIL b2b_ovf_beats: got ovf=%b beats=%0d want 0/%0d", a.ovf, cap_beats, DA);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] da, db, dc;
    da = 8'($urandom); db = ~da; dc = 8'($urandom_range(1, 254));
    send_a(da); model_wr(da);
    repeat (DA - 1) @(negedge clk);
    send_a(db);
    checks++;
    if (a.ovf !== 1'b1 || a.dout !== da) begin
      failures++; $display("FAIL ovr_drop: got ovf=%b dout=%h want 1/%h", a.ovf, a.dout, da);
    end
    send_a(dc); model_wr(dc);
    checks++;
    if (a.dout !== dc || a.busy !== 1'b1 || a.ovf !== 1'b1) begin
      failures++; $display("FAIL ovr_accept: got dout=%h busy=%b ovf=%b want %h/1/1", a.dout, a.busy, a.ovf, dc);
    end
    capture_a(0, 8'h00);
    for (int k = 0; k < DA; k++) begin
      checks++;
      if (cap_dat[k] !== exp_lag(k)) begin
        failures++; $display("FAIL ovr_lag%0d: got %h want %h", k, cap_dat[k], exp_lag(k));
      end
    end
    checks++;
    if (a.ovf !== 1'b1) begin
      failures++; $display("FAIL ovr_sticky: got ovf=%b want 1", a.ovf);
    end
    pulse_clr();
    checks++;
    if (a.ovf !== 1'b0 || a.dout !== dout_m) begin
      failures++; $display("FAIL ovr_clr: got ovf=%b dout=%h want 0/%h", a.ovf, a.dout, dout_m);
    end
  endtask

  task automatic test_random();
    logic ovf_exp = 1'b0;
    for (int it = 0; it < 6; it++) begin
      logic [7:0] d;
      int inj;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      d = 8'($urandom);
      send_a(d); model_wr(d);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DA - 1)) : 0;
      capture_a(inj, 8'($urandom));
      if (inj != 0) ovf_exp = 1'b1;
      for (int k = 0; k < DA; k++) begin
        checks++;
        if (cap_dat[k] !== exp_lag(k)) begin
          failures++; $display("FAIL rand%0d_lag%0d: got %h want %h", it, k, cap_dat[k], exp_lag(k));
        end
      end
      checks++;
      if (a.ovf !== ovf_exp || a.dout !== dout_m || cap_beats != DA) begin
        failures++;
        $display("FAIL rand%0d_state: got ovf=%b dout=%h beats=%0d want %b/%h/%0d",
                 it, a.ovf, a.dout, cap_beats, ovf_exp, dout_m, DA);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] d;
    d = 8'($urandom);
    send_a(d); model_wr(d);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a.dout, a.dshift, a.dshift_vld, a.dshift_lag, a.sout, a.busy, a.ovf} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got dout=%h dshift=%h vld=%b lag=%0d busy=%b want all 0",
               a.dout, a.dshift, a.dshift_vld, a.dshift_lag, a.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base_m = 0; dout_m = 8'h00; baseb_m = 0;
    @(negedge clk);
    d = 8'($urandom);
    send_a(d); model_wr(d);
    capture_a(0, 8'h00);
    for (int k = 0; k < DA; k++) begin
      checks++;
      if (cap_dat[k] !== exp_lag(k)) begin
        failures++; $display("FAIL midrst_lag%0d: got %h want %h", k, cap_dat[k], exp_lag(k));
      end
    end
  endtask

  task automatic test_clear();
    logic [7:0] s, n;
    for (int i = 0; i < DA; i++) begin
      send_a(8'hFF); model_wr(8'hFF);
      repeat (DA + 1) @(negedge clk);
    end
    s = 8'($urandom_range(0, 254));
    send_a(s); model_wr(s);
    repeat (5) @(negedge clk);
    a.clr = 1'b1;
    @(negedge clk);
    a.clr = 1'b0;
`ifdef SHIFTRAM_CLR_EN
    model_clear();
    checks++;
    if (a.dshift_vld !== 1'b0 || a.busy !== 1'b1 || a.dout !== 8'h00 || a.ovf !== 1'b0) begin
      failures++; $display("FAIL clr_enter: got vld=%b busy=%b dout=%h ovf=%b want 0/1/00/0",
                           a.dshift_vld, a.busy, a.dout, a.ovf);
    end
    a.din = 8'h5A; a.sin = 1'b1;
    @(negedge clk);
    a.sin = 1'b0;
    repeat (DA - 2) @(negedge clk);
    checks++;
    if (a.busy !== 1'b1) begin
      failures++; $display("FAIL clr_busy_hold: got busy=%b want 1", a.busy);
    end
    @(negedge clk);
    checks++;
    if (a.busy !== 1'b0 || a.ovf !== 1'b0 || a.dout !== 8'h00) begin
      failures++; $display("FAIL clr_exit: got busy=%b ovf=%b dout=%h want 0/0/00", a.busy, a.ovf, a.dout);
    end
`else
    checks++;
    if (a.dshift_vld !== 1'b1 || a.busy !== 1'b1 || a.dout !== s) begin
      failures++; $display("FAIL clr_noeffect: got vld=%b busy=%b dout=%h want 1/1/%h",
                           a.dshift_vld, a.busy, a.dout, s);
    end
    repeat (DA) @(negedge clk);
`endif
    n = 8'($urandom_range(1, 254));
    send_a(n); model_wr(n);
    capture_a(0, 8'h00);
    for (int k = 0; k < DA; k++) begin
      checks++;
      if (cap_dat[k] !== exp_lag(k)) begin
        failures++; $display("FAIL clr_lag%0d: got %h want %h", k, cap_dat[k], exp_lag(k));
      end
    end
    // clr coinciding with an overrun strobe must leave ovf low.
    send_a(8'h77); model_wr(8'h77);
    repeat (4) @(negedge clk);
    a.clr = 1'b1; a.sin = 1'b1; a.din = 8'h99;
    @(negedge clk);
    a.clr = 1'b0; a.sin = 1'b0;
    checks++;
    if (a.ovf !== 1'b0) begin
      failures++; $display("FAIL clr_wins: got ovf=%b want 0", a.ovf);
    end
`ifdef SHIFTRAM_CLR_EN
    model_clear();
`endif
    repeat (DA + 1) @(negedge clk);
  endtask

  task automatic test_small();
    for (int it = 0; it < 5; it++) begin
      logic [15:0] d;
      d = 16'($urandom);
      b.din = d; b.sin = 1'b1;
      @(negedge clk);
      b.sin = 1'b0;
      memb_m[baseb_m] = d;
      baseb_m = (baseb_m + 1) % DB;
      checks++;
      if (b.dout !== d || b.busy !== 1'b1) begin
        failures++; $display("FAIL small%0d_accept: got dout=%h busy=%b want %h/1", it, b.dout, b.busy, d);
      end
      for (int j = 1; j <= DB; j++) begin
        @(negedge clk);
        checks++;
        if ({b.dshift_vld, b.dshift_lag, b.dshift} !== {1'b1, 3'(j - 1), expb_lag(j - 1)}) begin
          failures++;
          $display("FAIL small%0d_beat%0d: got vld=%b lag=%0d data=%h want 1/%0d/%h",
                   it, j, b.dshift_vld, b.dshift_lag, b.dshift, j - 1, expb_lag(j - 1));
        end
      end
      checks++;
      if (b.busy !== 1'b0) begin
        failures++; $display("FAIL small%0d_busy: got busy=%b want 0", it, b.busy);
      end
    end
    checks++;
    if (b.ovf !== 1'b0) begin
      failures++; $display("FAIL small_ovf: got ovf=%b want 0", b.ovf);
    end
  endtask

  initial begin
    for (int i = 0; i < DA; i++) mem_m[i] = 8'h00;
    for (int i = 0; i < DB; i++) memb_m[i] = 16'h0000;
    base_m = 0; baseb_m = 0; dout_m = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_random();
    test_reset_mid_scan();
    test_clear();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
